serial_tx_framer: RTL and testbench

- Upstream stage that feeds the parallel-to-serial shift register.
- Accepts words over a valid/ready stream and buffers them in a small FIFO.
- Issues one load pulse plus the parallel word per frame, counts SIZE shifted bits, and drives an active-low frame select aligned with the serial bits.
- Enforces a programmable idle gap between frames; GAP=0 gives gapless back-to-back streaming.

---
 rtl/serial_pkg.sv | 29 ++
 rtl/serial_tx_framer_if.sv | 19 +
 rtl/serial_tx_framer_sync_fifo.sv | 68 ++++++
 rtl/serial_tx_framer.sv | 202 ++++++++++++++++++++
 tb/tb_serial_tx_framer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and width helpers for the serial transmit
//                framer and its receive-side companion.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_pkg;

    // Framer FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        SHIFT    = 2'd2,
        GAP_WAIT = 2'd3
    } state_e;

    // Bit counter width: enough to count 0..SIZE-1, never narrower than 1
    function automatic int cnt_w(input int size);
        return (size <= 2) ? 1 : $clog2(size);
    endfunction

    // Gap counter width: $clog2(GAP+1), never narrower than 1
    function automatic int gap_w(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_framer_if
//  Description : Upstream valid/ready word stream into the serial framer.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_tx_framer_if #(
    parameter int SIZE = 8
);
    logic            s_valid;
    logic            s_ready;
    logic [SIZE-1:0] s_data;

    // Producer side
    modport master (output s_valid, output s_data, input s_ready);
    // Framer side
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface
`default_nettype wire

// File: rtl/serial_tx_framer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered occupancy, full and empty
//                flags. Read data is the current head (first-word fall-through).
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rstn,
    input  wire logic                       push_i,
    input  wire logic [WIDTH-1:0]           wdata_i,
    input  wire logic                       pop_i,
    output logic      [WIDTH-1:0]           rdata_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic      [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             w_do_push;
    logic             w_do_pop;

    // A push while full is only honoured when a pop frees the slot in the same cycle
    assign w_do_push = push_i && (!full_q || pop_i);
    assign w_do_pop  = pop_i && !empty_q;
    assign count_d   = count_q + CW'(w_do_push) - CW'(w_do_pop);

    // Pointers, occupancy and flags; flags are derived from the next occupancy
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage array; contents need no reset since the flags gate every read
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/serial_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_framer
//  Description : Buffers upstream words and frames them for a downstream
//                parallel-to-serial shifter: one load pulse per word, an
//                active-low frame select aligned with the serial bits, and a
//                programmable idle gap between frames (GAP=0 streams gapless).
//  Revision    : 1.0  initial release
// ============================================================================
module serial_tx_framer
    import serial_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  wire logic            clk,
    input  wire logic            rstn,
    input  wire logic            enable,
    serial_tx_framer_if.slave    s,
    output logic                 shift_load,
    output logic [SIZE-1:0]      shift_data,
    output logic                 cs_n,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int CW  = cnt_w(SIZE);
    localparam int GW  = gap_w(GAP);
    localparam int FCW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] BIT_LAST   = CW'(SIZE - 1);
    localparam logic [CW-1:0] BIT_PENULT = CW'(SIZE - 2);
    // Last gap cycle in which a load decision is made (only used for GAP >= 2)
    localparam int            GAP_LAST_I = (GAP >= 2) ? (GAP - 2) : 0;
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_LAST_I);

    state_e          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            shift_load_q, shift_load_d;
    logic [SIZE-1:0] shift_data_q, shift_data_d;
    logic            cs_n_q, cs_n_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;

    logic            w_push;
    logic            w_pop;
    logic [SIZE-1:0] w_head;
    logic            w_full;
    logic            w_empty;
    logic [FCW-1:0]  w_fifo_cnt;
    logic [FCW-1:0]  w_fifo_cnt_nxt;
    logic            w_can_start;

    assign w_push    = s.s_valid && s.s_ready;
    assign s.s_ready = !w_full;

    sync_fifo #(
        .WIDTH (SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (w_push),
        .wdata_i (s.s_data),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_fifo_cnt)
    );

    // w_pop is only raised with w_can_start, so it never underflows the FIFO
    assign w_can_start    = !w_empty && enable;
    assign w_fifo_cnt_nxt = w_fifo_cnt + FCW'(w_push) - FCW'(w_pop);

    // State and output registers; every output is a flop
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            shift_load_q <= 1'b0;
            shift_data_q <= '0;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            shift_load_q <= shift_load_d;
            shift_data_q <= shift_data_d;
            cs_n_q       <= cs_n_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state and next outputs. Because outputs are registered, each load
    // decision is taken one cycle before the load pulse is to appear.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        shift_load_d = 1'b0;
        shift_data_d = shift_data_q;
        cs_n_d       = cs_n_q;
        frame_done_d = 1'b0;
        w_pop        = 1'b0;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                if (w_can_start) begin
                    w_pop        = 1'b1;
                    shift_load_d = 1'b1;
                    shift_data_d = w_head;
                    state_d      = LOAD;
                end
            end

            LOAD: begin
                // Shifter captures the word at the end of this cycle; MSB follows
                state_d   = SHIFT;
                bit_cnt_d = '0;
                cs_n_d    = 1'b0;
            end

            SHIFT: begin
                cs_n_d = 1'b0;
                if (bit_cnt_q == BIT_PENULT) begin
                    frame_done_d = 1'b1;
                    // Gapless: reload so the pulse lands on the final bit cycle
                    if (GAP == 0 && w_can_start) begin
                        w_pop        = 1'b1;
                        shift_load_d = 1'b1;
                        shift_data_d = w_head;
                    end
                end
                if (bit_cnt_q == BIT_LAST) begin
                    if (GAP == 0) begin
                        if (shift_load_q) begin
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                            cs_n_d  = 1'b1;
                        end
                    end else if (GAP == 1) begin
                        // One-cycle gap is the LOAD cycle itself
                        cs_n_d = 1'b1;
                        if (w_can_start) begin
                            w_pop        = 1'b1;
                            shift_load_d = 1'b1;
                            shift_data_d = w_head;
                            state_d      = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cs_n_d    = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = GAP_WAIT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end

            GAP_WAIT: begin
                cs_n_d = 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    if (w_can_start) begin
                        w_pop        = 1'b1;
                        shift_load_d = 1'b1;
                        shift_data_d = w_head;
                        state_d      = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
            end
        endcase

        busy_d = (w_fifo_cnt_nxt != '0) || (state_d != IDLE);
    end

    assign shift_load = shift_load_q;
    assign shift_data = shift_data_q;
    assign cs_n       = cs_n_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx_framer
//  Description : Self-checking bench for serial_tx_framer. Three instances
//                (GAP = 0, 1, 2) share one stimulus path selected by sel; a
//                model shifter turns load pulses into serial bits, which are
//                compared against a bit queue filled as words are accepted.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_tx_framer;

    logic       clk;
    logic       rstn;
    logic       enable;
    logic       tb_valid;
    logic [7:0] tb_data;
    int         sel;
    int         cyc;

    int n_checks;
    int n_errors;

    serial_tx_framer_if #(.SIZE(8)) ifg0 ();
    serial_tx_framer_if #(.SIZE(8)) ifg1 ();
    serial_tx_framer_if #(.SIZE(8)) ifg2 ();

    assign ifg0.s_valid = tb_valid && (sel == 0);
    assign ifg1.s_valid = tb_valid && (sel == 1);
    assign ifg2.s_valid = tb_valid && (sel == 2);
    assign ifg0.s_data  = tb_data;
    assign ifg1.s_data  = tb_data;
    assign ifg2.s_data  = tb_data;

    logic       ld0, ld1, ld2, cs0, cs1, cs2, bz0, bz1, bz2, fd0, fd1, fd2;
    logic [7:0] sd0, sd1, sd2;

    serial_tx_framer #(.SIZE(8), .DEPTH(4), .GAP(0)) u_dut_g0 (
        .clk(clk), .rstn(rstn), .enable(enable), .s(ifg0),
        .shift_load(ld0), .shift_data(sd0), .cs_n(cs0), .busy(bz0), .frame_done(fd0));
    serial_tx_framer #(.SIZE(8), .DEPTH(4), .GAP(1)) u_dut_g1 (
        .clk(clk), .rstn(rstn), .enable(enable), .s(ifg1),
        .shift_load(ld1), .shift_data(sd1), .cs_n(cs1), .busy(bz1), .frame_done(fd1));
    serial_tx_framer #(.SIZE(8), .DEPTH(4), .GAP(2)) u_dut_g2 (
        .clk(clk), .rstn(rstn), .enable(enable), .s(ifg2),
        .shift_load(ld2), .shift_data(sd2), .cs_n(cs2), .busy(bz2), .frame_done(fd2));

    // Observed outputs of the selected instance
    logic       obs_ready, obs_load, obs_csn, obs_busy, obs_fd;
    logic [7:0] obs_data;
    always_comb begin
        obs_ready = ifg1.s_ready; obs_load = ld1; obs_data = sd1;
        obs_csn   = cs1; obs_busy = bz1; obs_fd = fd1;
        if (sel == 0) begin
            obs_ready = ifg0.s_ready; obs_load = ld0; obs_data = sd0;
            obs_csn   = cs0; obs_busy = bz0; obs_fd = fd0;
        end else if (sel == 2) begin
            obs_ready = ifg2.s_ready; obs_load = ld2; obs_data = sd2;
            obs_csn   = cs2; obs_busy = bz2; obs_fd = fd2;
        end
    end

    // Model of the downstream shifter, reset together with the framer
    logic [7:0] sh;
    logic       ser;
    always_ff @(posedge clk) begin
        if (!rstn)         sh <= '0;
        else if (obs_load) sh <= obs_data;
        else               sh <= {sh[6:0], 1'b0};
    end
    assign ser = sh[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic exp_bits [$];
    int   ld_q [$];
    int   runs [$];
    int   gaps [$];
    int   fd_cnt;
    int   run;
    int   hi_run;
    bit   seen_low;
    bit   mon_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_bits.delete();
        ld_q.delete();
        runs.delete();
        gaps.delete();
        fd_cnt   = 0;
        run      = 0;
        hi_run   = 0;
        seen_low = 1'b0;
    endtask

    task automatic do_reset(input int which);
        mon_en   = 1'b0;
        sel      = which;
        tb_valid = 1'b0;
        rstn     = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        clear_sb();
        mon_en = 1'b1;
    endtask

    // Offer one word and wait (bounded) for it to be accepted
    task automatic send(input logic [7:0] d, output int acc);
        bit done;
        done     = 1'b0;
        acc      = -1;
        tb_data  = d;
        tb_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (obs_ready) begin
                acc = cyc;
                for (int b = 7; b >= 0; b--) exp_bits.push_back(d[b]);
                done = 1'b1;
            end
            tick();
        end
        tb_valid = 1'b0;
        if (!done) check("send_accept", obs_ready, 1);
    endtask

    // Monitor: serial bits against the scoreboard, load/frame_done/run tracking
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (obs_load) ld_q.push_back(cyc);
                if (obs_fd) fd_cnt++;
                if (!obs_csn) begin
                    if (exp_bits.size() == 0) check("spurious_bit", 32'(exp_bits.size()), 1);
                    else                      check("serial_bit", ser, exp_bits.pop_front());
                    if (seen_low && hi_run > 0) gaps.push_back(hi_run);
                    hi_run   = 0;
                    seen_low = 1'b1;
                    run++;
                end else begin
                    if (run != 0) runs.push_back(run);
                    run = 0;
                    if (seen_low) hi_run++;
                end
            end
        end
    end

    initial begin
        int acc;
        int k;
        logic [7:0] w4 [5];
        logic [7:0] w3 [4];
        w4 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        w3 = '{8'hFF, 8'h00, 8'hF0, 8'h0F};
        n_checks = 0; n_errors = 0;
        cyc = 0; enable = 1'b1; tb_valid = 1'b0; tb_data = '0; mon_en = 1'b0;
        clear_sb();

        // Test 1: reset state, then a single 0xA5 with GAP=1
        do_reset(1);
        check("rst_ready", obs_ready, 1);
        check("rst_load",  obs_load, 0);
        check("rst_data",  obs_data, 0);
        check("rst_csn",   obs_csn, 1);
        check("rst_busy",  obs_busy, 0);
        check("rst_fd",    obs_fd, 0);
        send(8'hA5, acc);
        while (cyc <= acc + 12) begin
            k = cyc - acc;
            check("t1_load", obs_load, (k == 2));
            check("t1_csn",  obs_csn, !(k >= 3 && k <= 10));
            check("t1_fd",   obs_fd, (k == 10));
            if (k == 1)  check("t1_busy_start", obs_busy, 1);
            if (k == 11) check("t1_busy_end", obs_busy, 0);
            tick();
        end
        check("t1_fd_count", fd_cnt, 1);
        check("t1_leftover", exp_bits.size(), 0);

        // Test 2: 0x81, 0x7E back-to-back with GAP=2
        do_reset(2);
        send(8'h81, acc);
        send(8'h7E, acc);
        repeat (30) tick();
        check("t2_loads", ld_q.size(), 2);
        if (ld_q.size() >= 2) check("t2_load_spacing", ld_q[1] - ld_q[0], 10);
        check("t2_gaps_seen", gaps.size(), 1);
        if (gaps.size() >= 1) check("t2_gap_len", gaps[0], 2);
        check("t2_fd_count", fd_cnt, 2);
        check("t2_leftover", exp_bits.size(), 0);

        // Test 3: GAP=0, four words preloaded then streamed gapless
        do_reset(0);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) send(w3[i], acc);
        enable = 1'b1;
        repeat (45) tick();
        check("t3_loads", ld_q.size(), 4);
        if (ld_q.size() == 4)
            for (int i = 1; i < 4; i++) check("t3_load_spacing", ld_q[i] - ld_q[i-1], 8);
        check("t3_runs", runs.size(), 1);
        if (runs.size() >= 1) check("t3_run_len", runs[0], 32);
        check("t3_fd_count", fd_cnt, 4);
        check("t3_leftover", exp_bits.size(), 0);

        // Test 4: five offers while disabled; fifth held until space frees
        do_reset(1);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) send(w4[i], acc);
        check("t4_full_ready", obs_ready, 0);
        tb_data  = w4[4];
        tb_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_held_ready", obs_ready, 0);
            check("t4_held_busy", obs_busy, 1);
        end
        check("t4_no_load", ld_q.size(), 0);
        enable = 1'b1;
        send(w4[4], acc);
        repeat (70) tick();
        check("t4_loads", ld_q.size(), 5);
        check("t4_fd_count", fd_cnt, 5);
        check("t4_leftover", exp_bits.size(), 0);
        check("t4_idle_busy", obs_busy, 0);

        // Test 5: one-cycle reset while bit 3 of 0xC3 is on the line
        do_reset(1);
        send(8'hC3, acc);
        while (cyc < acc + 7) tick();
        check("t5_mid_csn", obs_csn, 0);
        check("t5_bits_left", exp_bits.size(), 3);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("t5_csn",   obs_csn, 1);
        check("t5_ready", obs_ready, 1);
        check("t5_busy",  obs_busy, 0);
        check("t5_load",  obs_load, 0);
        clear_sb();
        repeat (20) tick();
        check("t5_no_load", ld_q.size(), 0);
        check("t5_no_fd", fd_cnt, 0);
        check("t5_idle_csn", obs_csn, 1);

        // Test 6: GAP=0, enable dropped during frame 1 of 3
        do_reset(0);
        enable = 1'b0;
        send(8'h3C, acc);
        send(8'h5A, acc);
        send(8'h96, acc);
        enable = 1'b1;
        for (int i = 0; i < 50 && ld_q.size() == 0; i++) tick();
        check("t6_started", ld_q.size(), 1);
        tick();
        tick();
        enable = 1'b0;
        repeat (16) tick();
        check("t6_paused_loads", ld_q.size(), 1);
        check("t6_paused_fd", fd_cnt, 1);
        check("t6_paused_csn", obs_csn, 1);
        check("t6_paused_busy", obs_busy, 1);
        check("t6_runs1", runs.size(), 1);
        if (runs.size() >= 1) check("t6_run1_len", runs[0], 8);
        enable = 1'b1;
        repeat (30) tick();
        check("t6_loads", ld_q.size(), 3);
        check("t6_fd_count", fd_cnt, 3);
        check("t6_runs2", runs.size(), 2);
        if (runs.size() >= 2) check("t6_run2_len", runs[1], 16);
        check("t6_leftover", exp_bits.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
